axi4_slave_bfm: RTL

Responder-side AXI4 bus functional model backed by an internal word-addressed memory. It accepts write bursts (AW/W/B) and read bursts (AR/R) from an AXI4 master, applies byte strobes, and generates BRESP/RRESP. Write and read channels are handled by independent FSMs, one outstanding burst per direction. It is the memory target for master-BFM and DUT-master testbenches on axi4_if.

---
 rtl/axi4_pkg.sv | 36 +++
 rtl/axi4_if.sv | 53 +++++
 rtl/axi4_burst_addr_gen.sv | 31 +++
 rtl/axi4_slave_bfm.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and channel FSM state types for the slave BFM.
// Response codes are ordered so the numerically larger code has the higher priority.
package axi4_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [1:0] BURST_RSVD  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      if (b > a) begin
         r = b;
      end else begin
         r = a;
      end
      return r;
   endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle with the channels the memory BFM understands.
// The slave modport is the responder view; the master modport is provided for initiators.
interface axi4_if #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 128,
   parameter int AXI4_ID_WIDTH      = 4
);
   logic [AXI4_ID_WIDTH-1:0]        awid;
   logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
   logic [7:0]                      awlen;
   logic [2:0]                      awsize;
   logic [1:0]                      awburst;
   logic                            awvalid;
   logic                            awready;
   logic [AXI4_DATA_WIDTH-1:0]      wdata;
   logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
   logic                            wlast;
   logic                            wvalid;
   logic                            wready;
   logic [AXI4_ID_WIDTH-1:0]        bid;
   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;
   logic [AXI4_ID_WIDTH-1:0]        arid;
   logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
   logic [7:0]                      arlen;
   logic [2:0]                      arsize;
   logic [1:0]                      arburst;
   logic                            arvalid;
   logic                            arready;
   logic [AXI4_ID_WIDTH-1:0]        rid;
   logic [AXI4_DATA_WIDTH-1:0]      rdata;
   logic [1:0]                      rresp;
   logic                            rlast;
   logic                            rvalid;
   logic                            rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output awready, wready, bid, bresp, bvalid,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address calculator for FIXED, INCR and WRAP bursts.
// The reserved burst encoding advances like INCR; flagging it as an error is the caller's job.
module axi4_burst_addr_gen
   import axi4_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr,
   input  logic [2:0]    size,
   input  logic [7:0]    len,
   input  logic [1:0]    burst,
   output logic [AW-1:0] next_addr
);

   logic [AW-1:0] inc_s;
   logic [AW-1:0] mask_s;
   logic [AW-1:0] incr_s;

   // Wrap boundary is the total burst size in bytes; the mask keeps the offset inside it.
   always_comb begin
      inc_s  = AW'(1) << size;
      mask_s = ((AW'(len) + AW'(1)) * inc_s) - AW'(1);
      incr_s = addr + inc_s;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask_s) | (incr_s & mask_s);
         default:     next_addr = incr_s;
      endcase
   end

endmodule

// File: rtl/axi4_slave_bfm.sv
// AXI4 responder BFM backed by a word-addressed memory; independent write and read FSMs,
// one outstanding burst per direction, byte strobes, and latched SLVERR/DECERR responses.
module axi4_slave_bfm
   import axi4_pkg::*;
#(
   parameter int AXI4_ADDRESS_WIDTH    = 32,
   parameter int AXI4_DATA_WIDTH       = 128,
   parameter int AXI4_ID_WIDTH         = 4,
   parameter int AXI4_MAX_BURST_LENGTH = 16,
   parameter int MEM_WORDS             = 1024,
   parameter int READY_DELAY           = 0
) (
   input  logic        clk,
   input  logic        rst,
   axi4_if.slave       slave,
   output logic [31:0] wr_count,
   output logic [31:0] rd_count
);

   localparam int AW   = AXI4_ADDRESS_WIDTH;
   localparam int DW   = AXI4_DATA_WIDTH;
   localparam int IW   = AXI4_ID_WIDTH;
   localparam int SB   = DW / 8;
   localparam int OFFS = $clog2(SB);
   localparam int MWB  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int CW   = (READY_DELAY > 0) ? $clog2(READY_DELAY + 1) : 1;
   localparam logic [CW-1:0] DLY_LOAD  = CW'(READY_DELAY);
   localparam logic [2:0]    MAX_SIZE  = 3'(OFFS);
   localparam logic [8:0]    MAX_BEATS = 9'(AXI4_MAX_BURST_LENGTH);

   logic [DW-1:0] mem [MEM_WORDS];

   function automatic logic out_of_range(input logic [AW-1:0] a);
      logic [AW-1:0] idx;
      idx = a >> OFFS;
      return idx >= AW'(MEM_WORDS);
   endfunction

   function automatic logic [MWB-1:0] word_index(input logic [AW-1:0] a);
      logic [AW-1:0] idx;
      idx = a >> OFFS;
      return idx[MWB-1:0];
   endfunction

   function automatic logic [1:0] request_err(input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
      logic [1:0] err;
      if ((({1'b0, len} + 9'd1) > MAX_BEATS) || (size > MAX_SIZE) || (burst == BURST_RSVD)) begin
         err = RESP_SLVERR;
      end else begin
         err = RESP_OKAY;
      end
      return err;
   endfunction

   // ---------------- write channel ----------------
   wr_state_t     wr_state_r, wr_next_s;
   logic [CW-1:0] wr_dly_r;
   logic [IW-1:0] wr_id_r;
   logic [AW-1:0] wr_addr_r, wr_next_addr_s;
   logic [7:0]    wr_len_r, wr_beat_r;
   logic [2:0]    wr_size_r;
   logic [1:0]    wr_burst_r, wr_err_r, wr_beat_err_s;
   logic [31:0]   wr_count_r;
   logic          awready_s, wready_s, bvalid_s;
   logic          aw_hs_s, w_hs_s, b_hs_s, wr_oob_s, wr_last_s;

   axi4_burst_addr_gen #(.AW(AW)) u_wr_addr_gen (
      .addr      (wr_addr_r),
      .size      (wr_size_r),
      .len       (wr_len_r),
      .burst     (wr_burst_r),
      .next_addr (wr_next_addr_s)
   );

   assign aw_hs_s   = awready_s && slave.awvalid;
   assign w_hs_s    = wready_s && slave.wvalid;
   assign b_hs_s    = bvalid_s && slave.bready;
   assign wr_oob_s  = out_of_range(wr_addr_r);
   assign wr_last_s = (wr_beat_r == wr_len_r);

   // Write FSM next state and channel handshake outputs.
   always_comb begin
      wr_next_s = wr_state_r;
      awready_s = 1'b0;
      wready_s  = 1'b0;
      bvalid_s  = 1'b0;
      case (wr_state_r)
         W_IDLE: begin
            awready_s = (wr_dly_r == CW'(0));
            if (slave.awvalid && awready_s) wr_next_s = W_DATA;
            else                            wr_next_s = W_IDLE;
         end
         W_DATA: begin
            wready_s = 1'b1;
            if (slave.wvalid && wr_last_s) wr_next_s = W_RESP;
            else                           wr_next_s = W_DATA;
         end
         W_RESP: begin
            bvalid_s = 1'b1;
            if (slave.bready) wr_next_s = W_IDLE;
            else              wr_next_s = W_RESP;
         end
         default: wr_next_s = W_IDLE;
      endcase
   end

   // Per-beat error: out-of-range word beats WLAST misplacement.
   always_comb begin
      if (wr_oob_s) begin
         wr_beat_err_s = RESP_DECERR;
      end else if (slave.wlast != wr_last_s) begin
         wr_beat_err_s = RESP_SLVERR;
      end else begin
         wr_beat_err_s = RESP_OKAY;
      end
   end

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) wr_state_r <= W_IDLE;
      else     wr_state_r <= wr_next_s;
   end

   // AWREADY delay counter, reloaded whenever the FSM is away from idle.
   always_ff @(posedge clk) begin
      if (rst || (wr_state_r != W_IDLE)) wr_dly_r <= DLY_LOAD;
      else if (wr_dly_r != CW'(0))       wr_dly_r <= wr_dly_r - CW'(1);
   end

   // Write burst context: capture on AW, advance on each W beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_id_r    <= {IW{1'b0}};
         wr_addr_r  <= {AW{1'b0}};
         wr_len_r   <= 8'd0;
         wr_size_r  <= 3'd0;
         wr_burst_r <= 2'd0;
         wr_beat_r  <= 8'd0;
         wr_err_r   <= RESP_OKAY;
      end else if (aw_hs_s) begin
         wr_id_r    <= slave.awid;
         wr_addr_r  <= slave.awaddr;
         wr_len_r   <= slave.awlen;
         wr_size_r  <= slave.awsize;
         wr_burst_r <= slave.awburst;
         wr_beat_r  <= 8'd0;
         wr_err_r   <= request_err(slave.awlen, slave.awsize, slave.awburst);
      end else if (w_hs_s) begin
         wr_addr_r  <= wr_next_addr_s;
         wr_beat_r  <= wr_beat_r + 8'd1;
         wr_err_r   <= resp_merge(wr_err_r, wr_beat_err_s);
      end
   end

   // Completed write burst counter.
   always_ff @(posedge clk) begin
      if (rst)         wr_count_r <= 32'd0;
      else if (b_hs_s) wr_count_r <= wr_count_r + 32'd1;
   end

   // Strobed memory write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_hs_s && !rst && !wr_oob_s) begin
         for (int b = 0; b < SB; b++) begin
            if (slave.wstrb[b]) mem[word_index(wr_addr_r)][8*b +: 8] <= slave.wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   rd_state_t     rd_state_r, rd_next_s;
   logic [CW-1:0] rd_dly_r;
   logic [IW-1:0] rd_id_r;
   logic [AW-1:0] rd_addr_r, rd_next_addr_s;
   logic [7:0]    rd_len_r, rd_beat_r;
   logic [2:0]    rd_size_r;
   logic [1:0]    rd_burst_r, rd_err_r, rresp_s;
   logic [31:0]   rd_count_r;
   logic [DW-1:0] rdata_s;
   logic          arready_s, rvalid_s, rlast_s, ar_hs_s, r_hs_s, rd_oob_s;

   axi4_burst_addr_gen #(.AW(AW)) u_rd_addr_gen (
      .addr      (rd_addr_r),
      .size      (rd_size_r),
      .len       (rd_len_r),
      .burst     (rd_burst_r),
      .next_addr (rd_next_addr_s)
   );

   assign ar_hs_s  = arready_s && slave.arvalid;
   assign r_hs_s   = rvalid_s && slave.rready;
   assign rd_oob_s = out_of_range(rd_addr_r);

   // Read FSM next state and channel handshake outputs.
   always_comb begin
      rd_next_s = rd_state_r;
      arready_s = 1'b0;
      rvalid_s  = 1'b0;
      rlast_s   = 1'b0;
      case (rd_state_r)
         R_IDLE: begin
            arready_s = (rd_dly_r == CW'(0));
            if (slave.arvalid && arready_s) rd_next_s = R_DATA;
            else                            rd_next_s = R_IDLE;
         end
         R_DATA: begin
            rvalid_s = 1'b1;
            rlast_s  = (rd_beat_r == rd_len_r);
            if (slave.rready && rlast_s) rd_next_s = R_IDLE;
            else                         rd_next_s = R_DATA;
         end
         default: rd_next_s = R_IDLE;
      endcase
   end

   // Read data/response for the current beat; out-of-range beats return zero.
   always_comb begin
      rdata_s = {DW{1'b0}};
      rresp_s = RESP_OKAY;
      if (rvalid_s && rd_oob_s) begin
         rresp_s = resp_merge(rd_err_r, RESP_DECERR);
      end else if (rvalid_s) begin
         rdata_s = mem[word_index(rd_addr_r)];
         rresp_s = rd_err_r;
      end else begin
         rresp_s = RESP_OKAY;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) rd_state_r <= R_IDLE;
      else     rd_state_r <= rd_next_s;
   end

   // ARREADY delay counter, same rule as the write side.
   always_ff @(posedge clk) begin
      if (rst || (rd_state_r != R_IDLE)) rd_dly_r <= DLY_LOAD;
      else if (rd_dly_r != CW'(0))       rd_dly_r <= rd_dly_r - CW'(1);
   end

   // Read burst context: capture on AR, advance on each R handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_id_r    <= {IW{1'b0}};
         rd_addr_r  <= {AW{1'b0}};
         rd_len_r   <= 8'd0;
         rd_size_r  <= 3'd0;
         rd_burst_r <= 2'd0;
         rd_beat_r  <= 8'd0;
         rd_err_r   <= RESP_OKAY;
      end else if (ar_hs_s) begin
         rd_id_r    <= slave.arid;
         rd_addr_r  <= slave.araddr;
         rd_len_r   <= slave.arlen;
         rd_size_r  <= slave.arsize;
         rd_burst_r <= slave.arburst;
         rd_beat_r  <= 8'd0;
         rd_err_r   <= request_err(slave.arlen, slave.arsize, slave.arburst);
      end else if (r_hs_s) begin
         rd_addr_r  <= rd_next_addr_s;
         rd_beat_r  <= rd_beat_r + 8'd1;
         rd_err_r   <= rresp_s;
      end
   end

   // Completed read burst counter.
   always_ff @(posedge clk) begin
      if (rst)                    rd_count_r <= 32'd0;
      else if (r_hs_s && rlast_s) rd_count_r <= rd_count_r + 32'd1;
   end

   assign slave.awready = awready_s;
   assign slave.wready  = wready_s;
   assign slave.bvalid  = bvalid_s;
   assign slave.bid     = wr_id_r;
   assign slave.bresp   = wr_err_r;
   assign slave.arready = arready_s;
   assign slave.rvalid  = rvalid_s;
   assign slave.rlast   = rlast_s;
   assign slave.rid     = rd_id_r;
   assign slave.rdata   = rdata_s;
   assign slave.rresp   = rresp_s;
   assign wr_count      = wr_count_r;
   assign rd_count      = rd_count_r;

endmodule
